// File: rtl/axi_wr_pkg.sv
// Shared AXI write-channel encodings, FSM state types and a saturating
// counter helper used by the burst master.
package axi_wr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {AW_IDLE, AW_PEND} aw_state_t;
  typedef enum logic {W_IDLE, W_DATA} w_state_t;

  // Up to two error events can land in one cycle (reserved burst + bad B).
  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] n);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0, n};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/axi_len_fifo.sv
// Small circular FIFO holding per-burst beat counts; head is read
// combinationally so the W path can compare against it every cycle.
module axi_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // alone define validity, and a reset-free array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_burst_master.sv
// AXI4 write burst master: one AW issue FSM, a pass-through W channel
// framed by a burst-length FIFO, and B-response accounting with error flags.
module axi_wr_burst_master
  import axi_wr_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [1:0]      cmd_burst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [DW-1:0]   wdata_in,
  input  logic [DW/8-1:0] wstrb_in,
  input  logic            wvalid_in,
  output logic            wready_out,
  output logic [AW-1:0]   axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [DW-1:0]   axi_wdata,
  output logic [DW/8-1:0] axi_wstrb,
  output logic            axi_wlast,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  output logic            busy,
  output logic            err,
  output logic [7:0]      err_cnt
);

  localparam int              OW      = $clog2(MAX_OUT) + 1;
  localparam int              CW      = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0]   MAX_CNT = OW'(MAX_OUT);

  aw_state_t       aw_state;
  w_state_t        w_state;
  logic [OW-1:0]   outstanding;
  logic [7:0]      beat;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            ne, cmd_hs, b_hs, w_hs, w_last_hs;
  logic            ev_burst, ev_resp, ev_spur;
  logic [1:0]      n_err;

  assign ne          = (w_state == W_DATA);
  assign axi_awsize  = 3'($clog2(DW/8));
  assign axi_bready  = (outstanding != '0);
  assign b_hs        = axi_bvalid & axi_bready;
  assign axi_wvalid  = wvalid_in & ne;
  assign wready_out  = axi_wready & ne;
  assign axi_wdata   = wdata_in;
  assign axi_wstrb   = wstrb_in;
  assign axi_wlast   = ne & (beat == fifo_head);
  assign w_hs        = axi_wvalid & axi_wready;
  assign w_last_hs   = w_hs & axi_wlast;
  assign busy        = (outstanding != '0) | (aw_state == AW_PEND);

  // A same-cycle B (or final W beat) frees the slot being claimed, so a full
  // master can still take a command without the count overshooting.
  assign cmd_ready = (aw_state == AW_IDLE)
                   & ((outstanding != MAX_CNT) | b_hs)
                   & (~fifo_full | w_last_hs);
  assign cmd_hs    = cmd_valid & cmd_ready;

  assign ev_burst = cmd_hs & (cmd_burst == BURST_RSVD);
  assign ev_resp  = b_hs & ((axi_bresp == RESP_SLVERR) | (axi_bresp == RESP_DECERR));
  assign ev_spur  = axi_bvalid & (outstanding == '0);
  assign n_err    = {1'b0, ev_burst} + {1'b0, ev_resp | ev_spur};

  axi_len_fifo #(.DEPTH(MAX_OUT), .WIDTH(8)) u_len_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_hs),
    .din   (cmd_len),
    .pop   (w_last_hs),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_state    <= AW_IDLE;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awburst <= '0;
    end else begin
      case (aw_state)
        AW_IDLE: if (cmd_hs) begin
          axi_awaddr  <= cmd_addr;
          axi_awlen   <= cmd_len;
          axi_awburst <= (cmd_burst == BURST_RSVD) ? BURST_INCR : cmd_burst;
          axi_awvalid <= 1'b1;
          aw_state    <= AW_PEND;
        end
        AW_PEND: if (axi_awready) begin
          axi_awvalid <= 1'b0;
          aw_state    <= AW_IDLE;
        end
        default: aw_state <= AW_IDLE;
      endcase
    end
  end

  // W_DATA mirrors "FIFO holds at least one burst"; it drops only when the
  // last queued burst finishes and nothing new is pushed that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      beat    <= '0;
    end else begin
      if (w_hs) beat <= axi_wlast ? 8'd0 : beat + 8'd1;
      case (w_state)
        W_IDLE: if (cmd_hs) w_state <= W_DATA;
        W_DATA: if (w_last_hs && !cmd_hs && fifo_count == CW'(1)) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      err         <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (cmd_hs && !b_hs)      outstanding <= outstanding + 1'b1;
      else if (b_hs && !cmd_hs) outstanding <= outstanding - 1'b1;
      if (n_err != 2'd0) begin
        err     <= 1'b1;
        err_cnt <= sat_add(err_cnt, n_err);
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Scoreboard bench: stimulus tasks queue the expected AW and W transfers,
// a negedge monitor pops and compares them as the master presents them.
module tb_axi_wr_burst_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } aw_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [1:0]  cmd_burst = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] wdata_in = '0;
  logic [7:0]  wstrb_in = '0;
  logic        wvalid_in = 1'b0;
  logic        wready_out;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready = 1'b1;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready = 1'b1;
  logic [1:0]  axi_bresp = 2'b00;
  logic        axi_bvalid = 1'b0;
  logic        axi_bready;
  logic        busy;
  logic        err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  aw_t aw_q[$];
  w_t  w_q[$];
  aw_t aw_exp;
  w_t  w_exp;

  axi_wr_burst_master #(.AW(32), .DW(64), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in), .wready_out(wready_out),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .busy(busy), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Monitor: handshakes seen at negedge complete on the following posedge.
  always @(negedge clk) begin
    if (axi_awvalid && axi_awready) begin
      if (aw_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL aw_unexpected: got addr %0h expected none", axi_awaddr);
      end else begin
        aw_exp = aw_q.pop_front();
        check("aw_payload", {axi_awaddr, axi_awlen, axi_awburst}, aw_exp);
      end
    end
    if (axi_wvalid && axi_wready) begin
      if (w_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w_unexpected: got data %0h expected none", axi_wdata);
      end else begin
        w_exp = w_q.pop_front();
        check("w_beat", {axi_wdata, axi_wstrb, axi_wlast}, w_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] b, input logic [1:0] exp_b);
    int t = 0;
    cmd_addr = a; cmd_len = l; cmd_burst = b; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    if (t >= 50) timeout("cmd_handshake");
    else aw_q.push_back('{addr: a, len: l, burst: exp_b});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int last_idx, input logic [63:0] seed);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      wdata_in  = seed + 64'(i);
      wstrb_in  = 8'hFF ^ 8'(i);
      wvalid_in = 1'b1;
      w_q.push_back('{data: wdata_in, strb: wstrb_in, last: (i == last_idx)});
      #1;
      while (!wready_out && t < 50) begin tick(); t++; end
      if (t >= 50) timeout("w_handshake");
      tick();
    end
    wvalid_in = 1'b0;
  endtask

  task automatic give_b(input logic [1:0] resp);
    int t = 0;
    axi_bresp  = resp;
    axi_bvalid = 1'b1;
    #1;
    while (!axi_bready && t < 50) begin tick(); t++; end
    if (t >= 50) timeout("b_handshake");
    tick();
    axi_bvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state; wvalid_in held high to prove W is gated by an empty FIFO.
    wvalid_in = 1'b1;
    do_reset();
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", {err, err_cnt}, 9'h000);
    check("rst_bready", axi_bready, 1'b0);
    check("rst_awaddr", {axi_awaddr, axi_awlen, axi_awburst}, 42'h0);
    check("awsize", axi_awsize, 3'd3);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    wvalid_in = 1'b0;

    // Single INCR burst of 4 beats.
    send_cmd(32'h1000, 8'd3, 2'b01, 2'b01);
    check("single_busy_active", busy, 1'b1);
    send_beats(4, 3, 64'hA000_0000_0000_0000);
    give_b(2'b00);
    check("single_busy_done", busy, 1'b0);
    check("single_err", err, 1'b0);

    // Outstanding limit: 4 single-beat bursts fill the master.
    for (int i = 0; i < 4; i++) send_cmd(32'h100 * (i + 1), 8'd0, 2'b01, 2'b01);
    for (int i = 0; i < 4; i++) send_beats(1, 0, 64'hB000 + 64'(16 * i));
    cmd_addr = 32'h0500; cmd_len = 8'd0; cmd_burst = 2'b01; cmd_valid = 1'b1;
    #1;
    check("full_stall_0", cmd_ready, 1'b0);
    tick();
    check("full_stall_1", cmd_ready, 1'b0);
    check("full_bready", axi_bready, 1'b1);
    axi_bresp = 2'b00; axi_bvalid = 1'b1;
    #1;
    check("full_release", cmd_ready, 1'b1);
    aw_q.push_back('{addr: 32'h0500, len: 8'd0, burst: 2'b01});
    tick();
    cmd_valid = 1'b0; axi_bvalid = 1'b0;
    check("full_still_busy", cmd_ready, 1'b0);
    send_beats(1, 0, 64'hB500);
    for (int i = 0; i < 4; i++) give_b(2'b00);
    check("full_drain_bready", axi_bready, 1'b0);
    check("full_drain_busy", busy, 1'b0);

    // AW backpressure: payload held stable, no new command accepted.
    axi_awready = 1'b0;
    send_cmd(32'h2000, 8'd1, 2'b10, 2'b10);
    for (int i = 0; i < 5; i++) begin
      check("stall_awvalid", axi_awvalid, 1'b1);
      check("stall_payload", {axi_awaddr, axi_awlen, axi_awburst}, {32'h2000, 8'd1, 2'b10});
      check("stall_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    axi_awready = 1'b1;
    tick();
    check("stall_aw_done", axi_awvalid, 1'b0);
    check("stall_cmd_ready_back", cmd_ready, 1'b1);
    send_beats(2, 1, 64'hC000);
    give_b(2'b00);

    // SLVERR on the middle of three bursts.
    for (int i = 0; i < 3; i++) begin
      send_cmd(32'h3000 + 32'(i * 16), 8'd1, 2'b01, 2'b01);
      send_beats(2, 1, 64'hD000 + 64'(i * 256));
    end
    give_b(2'b00);
    check("slverr_before", err, 1'b0);
    give_b(2'b10);
    check("slverr_after", {err, err_cnt}, {1'b1, 8'd1});
    give_b(2'b00);
    check("slverr_drained", busy, 1'b0);
    check("slverr_cnt_final", err_cnt, 8'd1);

    // Spurious B at idle, then a reserved burst type.
    do_reset();
    check("reset2_err", {err, err_cnt}, 9'h000);
    axi_bresp = 2'b00; axi_bvalid = 1'b1;
    tick();
    axi_bvalid = 1'b0;
    check("spur_err", {err, err_cnt}, {1'b1, 8'd1});
    check("spur_busy", busy, 1'b0);
    send_cmd(32'h4000, 8'd0, 2'b11, 2'b01);
    check("rsvd_errcnt", err_cnt, 8'd2);
    send_beats(1, 0, 64'hE000);
    give_b(2'b00);
    check("rsvd_final", err_cnt, 8'd2);

    // Reset during beat 2 of an 8-beat burst, then a clean burst.
    send_cmd(32'h6000, 8'd7, 2'b01, 2'b01);
    send_beats(1, -1, 64'hF000);
    wdata_in = 64'hF001; wstrb_in = 8'hFE; wvalid_in = 1'b1;
    w_q.push_back('{data: 64'hF001, strb: 8'hFE, last: 1'b0});
    rst = 1'b1;
    tick();
    check("midrst_wvalid", axi_wvalid, 1'b0);
    check("midrst_wready", wready_out, 1'b0);
    check("midrst_awvalid", axi_awvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_bready", axi_bready, 1'b0);
    check("midrst_err", {err, err_cnt}, 9'h000);
    rst = 1'b0;
    wvalid_in = 1'b0;
    tick();
    send_cmd(32'h7000, 8'd2, 2'b01, 2'b01);
    send_beats(3, 2, 64'h7700);
    give_b(2'b00);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_err", err, 1'b0);

    tick();
    check("aw_queue_empty", 32'(aw_q.size()), 32'd0);
    check("w_queue_empty", 32'(w_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_master.md
AXI_WR_BURST_MASTER -- requirements
Module: axi_wr_burst_master

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 64, data width; legal values 32, 64, 128.
REQ-003 Parameter MAX_OUT, default 4, maximum outstanding write bursts; power of 2, 1..16.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_addr/cmd_len/cmd_burst  in  AW/8/2  burst command: start address, beats-1, burst type.
REQ-007 cmd_valid  in  1; cmd_ready  out  1  command handshake.
REQ-008 wdata_in/wstrb_in  in  DW/DW/8  source write data and byte strobes.
REQ-009 wvalid_in  in  1; wready_out  out  1  source data handshake.
REQ-010 axi_awaddr/axi_awlen/axi_awsize/axi_awburst/axi_awvalid  out  AW/8/3/2/1; axi_awready  in  1.
REQ-011 axi_wdata/axi_wstrb/axi_wlast/axi_wvalid  out  DW/DW/8/1/1; axi_wready  in  1.
REQ-012 axi_bresp/axi_bvalid  in  2/1; axi_bready  out  1.
REQ-013 busy  out  1  outstanding count nonzero or AW pending; err  out  1  sticky error; err_cnt  out  8  saturating error count.

Function
REQ-014 AW FSM states: AW_IDLE, AW_PEND.
- AW_IDLE: cmd_ready=1 iff outstanding<MAX_OUT and length FIFO not full.
- cmd handshake registers the command into the axi_aw* outputs and enters AW_PEND.
REQ-015 AW_PEND: axi_awvalid=1 with address, length and burst held stable; axi_awready returns to AW_IDLE; cmd_ready=0 in AW_PEND.
REQ-016 axi_awsize SHALL be the constant log2(DW/8).
REQ-017 cmd_burst 2'b11 (reserved) SHALL be issued as INCR (2'b01), set err, and increment err_cnt.
REQ-018 On every cmd handshake, cmd_len SHALL be pushed into an internal length FIFO of depth MAX_OUT.
REQ-019 Outstanding counter: +1 on cmd handshake, -1 on B handshake, unchanged when both occur in the same cycle; width clog2(MAX_OUT)+1.
REQ-020 W path is combinational pass-through, gated by FIFO not empty (ne):
- axi_wvalid = wvalid_in & ne
- wready_out = axi_wready & ne
- axi_wdata/axi_wstrb = wdata_in/wstrb_in
REQ-021 W FSM states: W_IDLE (FIFO empty), W_DATA (FIFO not empty); W_DATA covers the beat-counter/head-entry behaviour in REQ-022..REQ-024.
REQ-022 Beat counter (8-bit) SHALL increment on each W handshake.
REQ-023 axi_wlast = ne & (beat counter == FIFO head).
REQ-024 A W handshake with wlast SHALL pop the FIFO and clear the beat counter.
REQ-025 W data MAY precede AW acceptance by the slave, but never precedes the cmd handshake for that burst.
REQ-026 axi_bready SHALL be 1 whenever outstanding>0, and 0 otherwise.
REQ-027 B handshake with axi_bresp of SLVERR or DECERR SHALL set err and increment err_cnt, saturating at 255.
REQ-028 axi_bvalid while outstanding==0 SHALL set err, increment err_cnt, and leave the counter at 0.
REQ-029 cmd and B handshakes with the counter at MAX_OUT SHALL be accepted in the same cycle, leaving the count at MAX_OUT.

Reset
REQ-030 rst SHALL set both FSMs idle, counters 0, FIFO empty, err 0, err_cnt 0, and all axi_*valid outputs 0.
REQ-031 rst asserted mid-burst SHALL abandon all in-flight state, with outputs at reset values the cycle after rst is sampled high.
REQ-032 axi_aw* payload outputs SHALL reset to 0.

Structure
REQ-033 Package axi_wr_pkg SHALL hold the burst constants (FIXED, INCR, WRAP) and the response constants (OKAY, EXOKAY, SLVERR, DECERR).
REQ-034 The length FIFO SHALL be a sub-module axi_len_fifo, parametrised by depth and width, providing full, empty and head outputs.

Verification
REQ-035 Single burst: addr 0x1000, len 3, INCR, slave always ready -> one AW; 4 W beats with wlast on beat 4; bresp OKAY; busy drops; err=0.
REQ-036 MAX_OUT=4: 5 back-to-back len-0 cmds, bvalid withheld -> 4 accepted and 5th stalled (cmd_ready=0); first B releases it.
REQ-037 Slave holds axi_awready=0 for 5 cycles -> axi_aw* stable throughout, cmd_ready=0 throughout.
REQ-038 bresp=SLVERR on burst 2 of 3 -> err=1 after that handshake, err_cnt=1, all bursts completed.
REQ-039 Spurious bvalid at idle, then cmd_burst=2'b11 -> err_cnt=2, awburst issued as 2'b01.
REQ-040 rst for 1 cycle at W beat 2 of len 7 -> next cycle all valid outputs 0, busy=0, FIFO empty; new burst then completes normally.
